// File: rtl/pingpong_buffer.sv
// pingpong_buffer: dual-bank word buffer between the JTAG host port and the DMA engine.
// One bank is mapped to each port. A switch handshake swaps the mapping once the DMA
// engine is idle, so one side can fill a bank while the other drains the previous one.
// Per-bank high-water counters report how many words have been written.
//
// Optional feature: define PP_PARITY_EN to store even parity per byte alongside each
// word and flag a sticky parity_error when a registered read returns inconsistent data.
// With the macro undefined there is no parity storage and parity_error is tied low.

module pingpong_buffer #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [DATA_WIDTH-1:0] dma_dataIn,
    input  logic                  dma_writeEnable,
    output logic [DATA_WIDTH-1:0] dma_dataOut,
    input  logic                  dma_busy,

    input  logic [ADDR_WIDTH-1:0] jtag_address,
    input  logic [DATA_WIDTH-1:0] jtag_dataIn,
    input  logic                  jtag_writeEnable,
    output logic [DATA_WIDTH-1:0] jtag_dataOut,

    input  logic                  switch_request,
    output logic                  switch_pending,
    output logic                  switch_done,
    output logic                  bank_select,

    input  logic                  clear_counts,
    output logic [ADDR_WIDTH:0]   dma_words,
    output logic [ADDR_WIDTH:0]   jtag_words,

    output logic                  parity_error
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitDma,
        StSwap
    } state_e;

    state_e state_q;
    logic   bank_select_q;
    logic   switch_pending_q;
    logic   switch_done_q;

    // Physical banks; contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    // Per-bank write port after routing through the current mapping.
    logic                  we_a;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] wdata_b;

    logic [DATA_WIDTH-1:0] dma_data_q;
    logic [DATA_WIDTH-1:0] jtag_data_q;

    logic [CNT_WIDTH-1:0]  count_a_q;
    logic [CNT_WIDTH-1:0]  count_a_d;
    logic [CNT_WIDTH-1:0]  count_b_q;
    logic [CNT_WIDTH-1:0]  count_b_d;

    // New count after a write at addr: max(count, addr + 1). addr + 1 never exceeds
    // DEPTH, so the counter saturates at DEPTH without explicit clamping.
    function automatic logic [CNT_WIDTH-1:0] high_water(input logic [CNT_WIDTH-1:0] cnt,
                                                        input logic [ADDR_WIDTH-1:0] addr);
        logic [CNT_WIDTH-1:0] top;
        top = {1'b0, addr} + CNT_WIDTH'(1);
        return (top > cnt) ? top : cnt;
    endfunction

    // ------------------------------------------------------------------------
    // Switch handshake
    // ------------------------------------------------------------------------

    // Switch FSM: bank_select flips only on the edge leaving StSwap, so every access
    // made during the swap cycle still uses the old mapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            bank_select_q    <= 1'b0;
            switch_pending_q <= 1'b0;
            switch_done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (switch_request) begin
                        if (dma_busy) begin
                            state_q          <= StWaitDma;
                            switch_pending_q <= 1'b1;
                        end else begin
                            state_q       <= StSwap;
                            switch_done_q <= 1'b1;
                        end
                    end
                end
                StWaitDma: begin
                    // Further requests are dropped here; nothing is queued.
                    if (!dma_busy) begin
                        state_q          <= StSwap;
                        switch_pending_q <= 1'b0;
                        switch_done_q    <= 1'b1;
                    end
                end
                StSwap: begin
                    state_q       <= StIdle;
                    switch_done_q <= 1'b0;
                    bank_select_q <= ~bank_select_q;
                end
                default: begin
                    state_q          <= StIdle;
                    switch_pending_q <= 1'b0;
                    switch_done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bank_select    = bank_select_q;
    assign switch_pending = switch_pending_q;
    assign switch_done    = switch_done_q;

    // ------------------------------------------------------------------------
    // Port-to-bank routing and storage
    // ------------------------------------------------------------------------

    // Route each port's write to its mapped bank; the two ports never share a bank.
    always_comb begin
        we_a    = dma_writeEnable;
        addr_a  = dma_address;
        wdata_a = dma_dataIn;
        we_b    = jtag_writeEnable;
        addr_b  = jtag_address;
        wdata_b = jtag_dataIn;
        if (bank_select_q) begin
            we_a    = jtag_writeEnable;
            addr_a  = jtag_address;
            wdata_a = jtag_dataIn;
            we_b    = dma_writeEnable;
            addr_b  = dma_address;
            wdata_b = dma_dataIn;
        end
    end

`ifdef PP_PARITY_EN
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [NUM_BYTES-1:0] par_a [DEPTH];
    logic [NUM_BYTES-1:0] par_b [DEPTH];
    logic [NUM_BYTES-1:0] dma_par_q;
    logic [NUM_BYTES-1:0] jtag_par_q;
    logic                 dma_par_bad;
    logic                 jtag_par_bad;
    logic                 parity_error_q;

    // Even parity per byte: the stored bit makes each byte-plus-bit hold an even
    // number of ones.
    function automatic logic [NUM_BYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NUM_BYTES-1:0] p;
        for (int i = 0; i < NUM_BYTES; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction
`endif

    // Bank storage writes (parity is generated alongside when enabled).
    always_ff @(posedge clock) begin
        if (we_a) begin
            mem_a[addr_a] <= wdata_a;
`ifdef PP_PARITY_EN
            par_a[addr_a] <= byte_parity(wdata_a);
`endif
        end
        if (we_b) begin
            mem_b[addr_b] <= wdata_b;
`ifdef PP_PARITY_EN
            par_b[addr_b] <= byte_parity(wdata_b);
`endif
        end
    end

    // Registered read ports; a same-cycle write to the same address yields old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            dma_data_q  <= '0;
            jtag_data_q <= '0;
`ifdef PP_PARITY_EN
            dma_par_q   <= '0;
            jtag_par_q  <= '0;
`endif
        end else begin
            dma_data_q  <= bank_select_q ? mem_b[dma_address]  : mem_a[dma_address];
            jtag_data_q <= bank_select_q ? mem_a[jtag_address] : mem_b[jtag_address];
`ifdef PP_PARITY_EN
            dma_par_q   <= bank_select_q ? par_b[dma_address]  : par_a[dma_address];
            jtag_par_q  <= bank_select_q ? par_a[jtag_address] : par_b[jtag_address];
`endif
        end
    end

    assign dma_dataOut  = dma_data_q;
    assign jtag_dataOut = jtag_data_q;

    // ------------------------------------------------------------------------
    // Parity checking
    // ------------------------------------------------------------------------

`ifdef PP_PARITY_EN
    // Check happens on the registered data so the flag lines up with the bad word.
    assign dma_par_bad  = byte_parity(dma_data_q)  != dma_par_q;
    assign jtag_par_bad = byte_parity(jtag_data_q) != jtag_par_q;

    // Sticky error; cleared together with the high-water counters.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            parity_error_q <= 1'b0;
        end else if (dma_par_bad || jtag_par_bad) begin
            parity_error_q <= 1'b1;
        end
    end

    assign parity_error = parity_error_q | dma_par_bad | jtag_par_bad;
`else
    assign parity_error = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // High-water counters
    // ------------------------------------------------------------------------

    // Next counts follow the physical bank written, independent of the mapping.
    always_comb begin
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        if (we_a) begin
            count_a_d = high_water(count_a_q, addr_a);
        end
        if (we_b) begin
            count_b_d = high_water(count_b_q, addr_b);
        end
    end

    // Counter state; clear_counts beats a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

    // Port views switch in the same cycle as bank_select.
    assign dma_words  = bank_select_q ? count_b_q : count_a_q;
    assign jtag_words = bank_select_q ? count_a_q : count_b_q;

endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed bench for pingpong_buffer: a reference model of both banks and both
// high-water counters predicts every read and count; read expectations go through
// per-port queues and are popped when the registered data appears.

module tb_pingpong_buffer;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] dma_address = '0;
    logic [DW-1:0] dma_dataIn = '0;
    logic          dma_writeEnable = 1'b0;
    logic [DW-1:0] dma_dataOut;
    logic          dma_busy = 1'b0;
    logic [AW-1:0] jtag_address = '0;
    logic [DW-1:0] jtag_dataIn = '0;
    logic          jtag_writeEnable = 1'b0;
    logic [DW-1:0] jtag_dataOut;
    logic          switch_request = 1'b0;
    logic          switch_pending;
    logic          switch_done;
    logic          bank_select;
    logic          clear_counts = 1'b0;
    logic [AW:0]   dma_words;
    logic [AW:0]   jtag_words;
    logic          parity_error;

    pingpong_buffer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .dma_address      (dma_address),
        .dma_dataIn       (dma_dataIn),
        .dma_writeEnable  (dma_writeEnable),
        .dma_dataOut      (dma_dataOut),
        .dma_busy         (dma_busy),
        .jtag_address     (jtag_address),
        .jtag_dataIn      (jtag_dataIn),
        .jtag_writeEnable (jtag_writeEnable),
        .jtag_dataOut     (jtag_dataOut),
        .switch_request   (switch_request),
        .switch_pending   (switch_pending),
        .switch_done      (switch_done),
        .bank_select      (bank_select),
        .clear_counts     (clear_counts),
        .dma_words        (dma_words),
        .jtag_words       (jtag_words),
        .parity_error     (parity_error)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bank A = 0, bank B = 1; sel mirrors the expected bank_select.
    logic [DW-1:0] model_a [512];
    logic [DW-1:0] model_b [512];
    int            cnt_a = 0;
    int            cnt_b = 0;
    bit            sel = 1'b0;
    logic [DW-1:0] exp_dma  [$];
    logic [DW-1:0] exp_jtag [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_write(input bit bank, input int addr, input logic [DW-1:0] data,
                                        input bit count);
        if (bank) model_b[addr] = data;
        else      model_a[addr] = data;
        if (count) begin
            if (bank) cnt_b = (addr + 1 > cnt_b) ? addr + 1 : cnt_b;
            else      cnt_a = (addr + 1 > cnt_a) ? addr + 1 : cnt_a;
        end
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_dma_words"},  dma_words,  sel ? cnt_b : cnt_a);
        check({tag, "_jtag_words"}, jtag_words, sel ? cnt_a : cnt_b);
    endtask

    task automatic dma_write(input int addr, input logic [DW-1:0] data);
        dma_address     = addr[AW-1:0];
        dma_dataIn      = data;
        dma_writeEnable = 1'b1;
        tick();
        dma_writeEnable = 1'b0;
        model_write(sel, addr, data, 1'b1);
    endtask

    task automatic jtag_write(input int addr, input logic [DW-1:0] data);
        jtag_address     = addr[AW-1:0];
        jtag_dataIn      = data;
        jtag_writeEnable = 1'b1;
        tick();
        jtag_writeEnable = 1'b0;
        model_write(~sel, addr, data, 1'b1);
    endtask

    task automatic dma_read(input string tag, input int addr);
        dma_address = addr[AW-1:0];
        exp_dma.push_back(sel ? model_b[addr] : model_a[addr]);
        tick();
        check(tag, dma_dataOut, exp_dma.pop_front());
    endtask

    task automatic jtag_read(input string tag, input int addr);
        jtag_address = addr[AW-1:0];
        exp_jtag.push_back(sel ? model_a[addr] : model_b[addr]);
        tick();
        check(tag, jtag_dataOut, exp_jtag.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values
        tick();
        tick();
        check("rst_bank_select", bank_select, 1'b0);
        check("rst_pending", switch_pending, 1'b0);
        check("rst_done", switch_done, 1'b0);
        check("rst_dma_words", dma_words, 0);
        check("rst_jtag_words", jtag_words, 0);
        check("rst_parity", parity_error, 1'b0);
        check("rst_dma_data", dma_dataOut, 0);
        check("rst_jtag_data", jtag_dataOut, 0);
        reset = 1'b0;

        // ---- basic fill, read-during-write returns old data
        dma_write(0, 32'h0000_0000);
        jtag_write(0, 32'h0000_0000);
        dma_write(5, 32'h1111_1111);
        jtag_write(5, 32'hDEAD_BEEF);
        dma_write(7, 32'hA5A5_0007);
        dma_address     = 9'd7;
        dma_dataIn      = 32'h5A5A_0007;
        dma_writeEnable = 1'b1;
        exp_dma.push_back(model_a[7]);
        tick();
        dma_writeEnable = 1'b0;
        model_write(1'b0, 7, 32'h5A5A_0007, 1'b1);
        check("rdw_old_data", dma_dataOut, exp_dma.pop_front());
        dma_read("rdw_new_data", 7);
        check_counts("init");

        // ---- swap with DMA idle
        switch_request = 1'b1;
        tick();
        switch_request = 1'b0;
        check("swap1_done", switch_done, 1'b1);
        check("swap1_sel_hold", bank_select, 1'b0);
        tick();
        sel = 1'b1;
        check("swap1_done_end", switch_done, 1'b0);
        check("swap1_sel", bank_select, 1'b1);
        check_counts("swap1");
        dma_read("swap1_dma_rd5", 5);
        jtag_read("swap1_jtag_rd5", 5);

        // ---- deferred swap plus an ignored second request
        dma_busy       = 1'b1;
        switch_request = 1'b1;
        tick();
        switch_request = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("wait_pending", switch_pending, 1'b1);
            check("wait_sel", bank_select, 1'b1);
            check("wait_done", switch_done, 1'b0);
            switch_request = (i == 3);
            tick();
            switch_request = 1'b0;
        end
        dma_busy = 1'b0;
        tick();
        check("defer_done", switch_done, 1'b1);
        check("defer_pending", switch_pending, 1'b0);
        check("defer_sel_hold", bank_select, 1'b1);
        tick();
        sel = 1'b0;
        check("defer_sel", bank_select, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("no_second_done", switch_done, 1'b0);
            check("no_second_sel", bank_select, 1'b0);
            tick();
        end

        // ---- high-water counters
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        check_counts("clear");
        jtag_write(3, 32'h0000_0003);
        jtag_write(10, 32'h0000_000A);
        jtag_write(7, 32'h0000_0007);
        check_counts("hw_11");
        jtag_write(511, 32'hFFFF_01FF);
        check_counts("hw_512");
        dma_write(2, 32'h0000_0002);
        check_counts("hw_dma");

        // swap, with a JTAG write landing in the swap cycle (old mapping -> bank B)
        switch_request = 1'b1;
        tick();
        switch_request = 1'b0;
        check("swap2_done", switch_done, 1'b1);
        check_counts("swap2_cycle");
        jtag_address     = 9'd40;
        jtag_dataIn      = 32'hCAFE_0040;
        jtag_writeEnable = 1'b1;
        tick();
        jtag_writeEnable = 1'b0;
        model_write(1'b1, 40, 32'hCAFE_0040, 1'b1);
        sel = 1'b1;
        check("swap2_sel", bank_select, 1'b1);
        check_counts("swap2");
        dma_read("swap_cycle_write", 40);
        dma_read("dma_rd511", 511);

        // clear wins over a same-cycle write, but the data is still stored
        clear_counts     = 1'b1;
        jtag_address     = 9'd20;
        jtag_dataIn      = 32'h0000_BEEF;
        jtag_writeEnable = 1'b1;
        tick();
        clear_counts     = 1'b0;
        jtag_writeEnable = 1'b0;
        model_write(~sel, 20, 32'h0000_BEEF, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        check_counts("clear_vs_write");
        jtag_read("clear_write_data", 20);

        // ---- reset while waiting for DMA
        dma_busy       = 1'b1;
        switch_request = 1'b1;
        tick();
        switch_request = 1'b0;
        check("rst_wait_pending_pre", switch_pending, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel   = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        check("rst_wait_pending", switch_pending, 1'b0);
        check("rst_wait_sel", bank_select, 1'b0);
        check("rst_wait_done", switch_done, 1'b0);
        check_counts("rst_wait");
        dma_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_lost_done", switch_done, 1'b0);
            check("rst_lost_sel", bank_select, 1'b0);
        end
        dma_read("mem_kept_a5", 5);
        jtag_read("mem_kept_b40", 40);

        // ---- parity
`ifdef PP_PARITY_EN
        check("par_clean", parity_error, 1'b0);
        jtag_write(9, 32'h1234_5678);
        dut.par_b[9] = dut.par_b[9] ^ 4'b0001;
        jtag_read("par_bad_data", 9);
        check("par_flag", parity_error, 1'b1);
        jtag_address = 9'd5;
        tick();
        check("par_sticky", parity_error, 1'b1);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check("par_cleared", parity_error, 1'b0);
`else
        check("par_off_a", parity_error, 1'b0);
        jtag_read("par_off_rd", 5);
        check("par_off_b", parity_error, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_buffer.md
Name: pingpong_buffer

Overview:
- Dual-bank 32-bit word buffer between the JTAG interface (host side) and the DMA engine (bus side).
- At any time, one bank is mapped to the DMA port and the other to the JTAG port.
- A switch handshake swaps the mapping, but only while the DMA engine is idle. One side can then fill a bank while the other drains the previous one.
- Per-bank high-water counters tell the host how many words are valid.

Parameters:
ADDR_WIDTH, 9, word address width per bank (bank depth 2^ADDR_WIDTH = 512 words)
DATA_WIDTH, 32, word width in bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
dma_address  in  ADDR_WIDTH  DMA-side word address
dma_dataIn  in  DATA_WIDTH  DMA-side write data
dma_writeEnable  in  1  DMA-side write strobe
dma_dataOut  out  DATA_WIDTH  DMA-side read data, 1-cycle latency
dma_busy  in  1  DMA engine busy; while high, no swap is allowed
jtag_address  in  ADDR_WIDTH  JTAG-side word address
jtag_dataIn  in  DATA_WIDTH  JTAG-side write data
jtag_writeEnable  in  1  JTAG-side write strobe
jtag_dataOut  out  DATA_WIDTH  JTAG-side read data, 1-cycle latency
switch_request  in  1  single-cycle pulse requesting a bank swap
switch_pending  out  1  a request is waiting for dma_busy to drop
switch_done  out  1  single-cycle pulse: swap took effect
bank_select  out  1  0: DMA uses bank A, JTAG uses bank B; 1: mapping reversed
clear_counts  in  1  clears both high-water counters
dma_words  out  ADDR_WIDTH+1  high-water count of the bank currently on the DMA side
jtag_words  out  ADDR_WIDTH+1  high-water count of the bank currently on the JTAG side
parity_error  out  1  sticky parity error (only with PP_PARITY_EN)

Behaviour:
Reset and memory:
- Reset values: bank_select=0, switch_pending=0, switch_done=0, both counters 0, parity_error=0, dma_dataOut=0, jtag_dataOut=0.
- Memory contents are not reset.

Read/write ports:
- Each port reads its mapped bank through a registered output: address in cycle N, data in cycle N+1.
- Read-during-write to the same address returns the old data.
- The two ports always address different banks, so no collision is possible.
- Writes take effect at the clock edge when the write strobe is high.

Switch FSM:
- States: IDLE, WAIT_DMA, SWAP.
- IDLE: on switch_request, go to SWAP if dma_busy=0, otherwise to WAIT_DMA.
- WAIT_DMA: switch_pending=1. Go to SWAP on the first cycle with dma_busy=0.
- SWAP: lasts one cycle. switch_done=1 during it. bank_select toggles at the edge leaving SWAP. Next state is IDLE.
- Accesses in the SWAP cycle (reads and writes) use the old mapping. The first access on the new mapping happens in the cycle after SWAP.
- switch_request in WAIT_DMA or SWAP is ignored and is not queued.

Reset mid-operation:
- Reset in any state returns the FSM to IDLE with bank_select=0.
- A pending request is lost.

High-water counters:
- One counter per physical bank, width ADDR_WIDTH+1.
- On a write to address a: count = max(count, a+1). Writing address 511 gives 512.
- Counters saturate naturally at 512; no wrap.
- dma_words and jtag_words are multiplexed by bank_select and follow the swap in the same cycle as bank_select.
- clear_counts zeroes both counters. If a write occurs in the same cycle, clear wins and the write is not counted.

Optional Feature:
Macro: PP_PARITY_EN

Defined:
- Each word stores 4 extra bits: even parity per byte, generated on write.
- Parity is checked on every registered read on both ports.
- A mismatch sets parity_error on the cycle the bad data appears on the output.
- parity_error stays set until reset or clear_counts.

Undefined:
- No parity storage.
- parity_error is tied to 0.

Test Plan:
1. Swap with DMA idle: JTAG writes 0xDEADBEEF@5 with bank_select=0; pulse switch_request with dma_busy=0 -> switch_done high 1 cycle later for 1 cycle, then bank_select=1. DMA reads @5 -> dma_dataOut=0xDEADBEEF next cycle.
2. Deferred swap: dma_busy=1, pulse switch_request -> switch_pending=1 and bank_select unchanged for 10 cycles. Drop dma_busy -> SWAP next cycle, switch_done pulse, bank_select toggles, switch_pending=0.
3. Ignored request: second switch_request during WAIT_DMA -> exactly one swap, one switch_done pulse.
4. High-water: JTAG writes @3, @10, @7 -> jtag_words=11. Write @511 -> 512. After swap, dma_words=512 and jtag_words = the other bank's count. clear_counts together with a write @20 -> both counters 0.
5. Reset mid-WAIT_DMA: reset asserted while switch_pending=1 -> next cycle state IDLE, bank_select=0, switch_pending=0, no switch_done.
6. Parity (PP_PARITY_EN defined): force a stored parity bit flip via backdoor, read that word -> parity_error=1 with the data, stays 1 until clear_counts. With the macro undefined -> parity_error always 0.
